// File: rtl/nios_mtl_button_pkg.sv
// Shared constants for the button PIO: register addresses and edge-mode encodings.
package nios_mtl_button_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/nios_mtl_button_filter.sv
// One input bit: synchroniser chain followed by the filter register f.
// Debounce counter present only when NIOS_MTL_BUTTON_DEBOUNCE_EN is defined.
module nios_mtl_button_filter
  import nios_mtl_button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic prime,
  input  logic in_bit,
  output logic s,
  output logic f
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   f_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
  assign f = f_q;

`ifdef NIOS_MTL_BUTTON_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // f follows s only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else if (prime) begin
      f_q   <= s;
      cnt_q <= '0;
    end else if (s != f_q) begin
      if (cnt_q == CntLast) begin
        f_q   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q <= 1'b0;
    end else begin
      f_q <= s;
    end
  end
`endif

endmodule

// File: rtl/nios_mtl_button_pio.sv
// Avalon-MM input PIO for buttons: per-bit filters, edge capture (W1C), IRQ mask, level IRQ.
// Optional debounce enabled by defining NIOS_MTL_BUTTON_DEBOUNCE_EN.
module nios_mtl_button_pio
  import nios_mtl_button_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  s_vec;
  logic [WIDTH-1:0]  f;
  logic [WIDTH-1:0]  f_d_q;
  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  cap_q, cap_d;
  logic [WIDTH-1:0]  edge_raw, edge_det, clr;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q;
  logic [PrimeW-1:0] prime_cnt_q;
  logic              primed_q;
  logic              wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_filter
    nios_mtl_button_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk   (clk),
      .reset (reset),
      .prime (~primed_q),
      .in_bit(in_port[i]),
      .s     (s_vec[i]),
      .f     (f[i])
    );
  end

  // Priming lasts SYNC_STAGES+1 cycles so the synchronisers hold real pin values before edges count.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else if (!primed_q) begin
      if (prime_cnt_q == PrimeW'(SYNC_STAGES)) begin
        primed_q <= 1'b1;
      end else begin
        prime_cnt_q <= prime_cnt_q + 1'b1;
      end
    end
  end

  // f_d tracks s while priming so the first primed cycle sees f == f_d.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_d_q <= '0;
    end else if (!primed_q) begin
      f_d_q <= s_vec;
    end else begin
      f_d_q <= f;
    end
  end

  assign wr = chipselect & ~write_n;

  always_comb begin
    edge_raw = f ^ f_d_q;
    if (EDGE_MODE == EDGE_RISING) begin
      edge_raw = f & ~f_d_q;
    end else if (EDGE_MODE == EDGE_FALLING) begin
      edge_raw = ~f & f_d_q;
    end
    edge_det = primed_q ? edge_raw : '0;
    clr      = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    // Set wins over a simultaneous clear.
    cap_d    = (cap_q & ~clr) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = f;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = cap_q;
      ADDR_RSVD:    readdata_d = '0;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr && address == ADDR_IRQMASK) begin
        mask_q <= writedata[WIDTH-1:0];
      end
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      irq_q      <= |(cap_q & mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_mtl_button_pio.sv
// Bench for nios_mtl_button_pio: directed steps plus random traffic against a behavioural model.
module tb_nios_mtl_button_pio;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int DC   = 4;
  localparam int MODE = 1;
`ifdef NIOS_MTL_BUTTON_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  // Cycles from an in_port change until f changes.
  localparam int LAT = DEB ? S + DC : S + 1;

  logic         clk;
  logic         reset;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] in_port;
  logic         irq;

  nios_mtl_button_pio #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DC),
    .EDGE_MODE      (MODE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: pin history stands in for the synchroniser delay.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_f, m_fd, m_cap, m_mask;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           m_age;
  int           m_run[W];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [W-1:0] s, e, clr;
    bit primed;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back('0);
      m_f = '0; m_fd = '0; m_cap = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0; m_age = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      return;
    end
    s = hist.pop_front();
    hist.push_back(in_port);
    primed = (m_age > S);
    case (address)
      2'd0:    m_rd = 32'(m_f);
      2'd2:    m_rd = 32'(m_mask);
      2'd3:    m_rd = 32'(m_cap);
      default: m_rd = 32'd0;
    endcase
    m_irq = |(m_cap & m_mask);
    case (MODE)
      0:       e = m_f & ~m_fd;
      1:       e = ~m_f & m_fd;
      default: e = m_f ^ m_fd;
    endcase
    if (!primed) e = '0;
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    m_cap = (m_cap & ~clr) | e;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    if (!primed) begin
      m_f = s;
      m_fd = s;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_fd = m_f;
      for (int i = 0; i < W; i++) begin
        if (!DEB) begin
          m_f[i] = s[i];
        end else if (s[i] != m_f[i]) begin
          m_run[i]++;
          if (m_run[i] >= DC) begin
            m_f[i] = s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    if (m_age < 1000) m_age++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_rd", readdata, m_rd);
    check("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; in_port = 4'hF; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // Reset with idle-high buttons.
    ticks(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    ticks(5);
    check("data_primed", readdata, 32'hF);
    address = 2'd3;
    tick();
    check("cap_after_prime", readdata, 32'h0);
    check("irq_after_prime", 32'(irq), 32'h0);

    // Falling edge on bit 0 with mask bit 0 set.
    bus_write(2'd2, 32'h1);
    address = 2'd0;
    in_port = 4'hE;
    ticks(LAT);
    check("data_before_lat", readdata, 32'hF);
    tick();
    check("data_fall", readdata, 32'hE);
    address = 2'd3;
    tick();
    check("cap_fall", readdata, 32'h1);
    check("irq_fall", 32'(irq), 32'h1);

    // Clear of EDGECAP[0] coinciding with a new falling edge: set wins.
    in_port = 4'hF;
    ticks(LAT + 3);
    in_port = 4'hE;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_age > S && (~m_f[0] & m_fd[0])) begin
        bus_write(2'd3, 32'h1);
        found = 1'b1;
      end else begin
        tick();
      end
    end
    check("set_wins_edge_seen", 32'(found), 32'h1);
    address = 2'd3;
    tick();
    check("set_wins_cap", readdata, 32'h1);
    check("set_wins_irq", 32'(irq), 32'h1);

`ifdef NIOS_MTL_BUTTON_DEBOUNCE_EN
    bus_write(2'd2, 32'h0);
    in_port = 4'hF;
    ticks(LAT + 3);
    bus_write(2'd3, 32'hF);
    address = 2'd0;
    ticks(2);
    // Short glitch on bit 1 is filtered.
    in_port = 4'hD;
    ticks(3);
    in_port = 4'hF;
    ticks(12);
    check("glitch_data", readdata, 32'hF);
    address = 2'd3;
    tick();
    check("glitch_cap", readdata, 32'h0);
    // Pulse of exactly DEBOUNCE_CYCLES is accepted.
    address = 2'd0;
    in_port = 4'hD;
    ticks(4);
    in_port = 4'hF;
    ticks(2);
    check("pulse_data_early", readdata, 32'hF);
    tick();
    check("pulse_data", readdata, 32'hD);
    address = 2'd3;
    tick();
    check("pulse_cap", readdata, 32'h2);
    check("pulse_irq_masked", 32'(irq), 32'h0);
    ticks(3);
    bus_write(2'd2, 32'h2);
    check("mask_irq_same", 32'(irq), 32'h0);
    tick();
    check("mask_irq_next", 32'(irq), 32'h1);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
      chipselect = $urandom_range(0, 1) == 1;
      write_n    = $urandom_range(0, 2) != 0;
      address    = 2'($urandom);
      writedata  = $urandom;
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;

    // Reserved address and deselected writes.
    address = 2'd1;
    tick();
    check("rsvd_read", readdata, 32'h0);
    bus_write(2'd2, 32'h5);
    chipselect = 1'b0; write_n = 1'b0; address = 2'd2; writedata = 32'hA;
    tick();
    address = 2'd3; writedata = 32'hF;
    tick();
    write_n = 1'b1;
    address = 2'd2;
    tick();
    check("mask_deselect", readdata, 32'h5);

    // Reset with all capture bits pending.
    in_port = 4'hF;
    ticks(LAT + 3);
    bus_write(2'd3, 32'hF);
    in_port = 4'h0;
    ticks(LAT + 3);
    address = 2'd3;
    tick();
    check("cap_all", readdata, 32'hF);
    reset = 1'b1;
    tick();
    check("rst_cap_rd", readdata, 32'h0);
    check("rst_cap_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    ticks(8);
    check("release_cap", readdata, 32'h0);
    check("release_irq", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
